// File: rtl/sos_pkg.sv
// Shared definitions for the cascaded-biquad stage scheduler:
// default geometry and the FSM state encoding.
`timescale 1ns/1ps
package sos_pkg;

   localparam int unsigned SOS_NUM_STAGES = 4;
   localparam int unsigned SOS_DW         = 24;
   localparam int unsigned SOS_TIMEOUT    = 64;
   localparam int unsigned SOS_CNT_W      = 11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_OUT   = 2'd3
   } sos_state_e;

endpackage

// File: rtl/sos_stage_sched.sv
// Time-shares one external biquad unit across NUM_STAGES cascaded stages.
// One sample is in flight at a time: it is accepted in IDLE, walks through
// ISSUE/WAIT once per stage and is presented in OUT until downstream takes it.
// The output register adds one cycle in OUT, so out_valid rises
// 2*NUM_STAGES+1 edges after the accepting edge when the unit answers at once.
`timescale 1ns/1ps
module sos_stage_sched
   import sos_pkg::*;
#(
   parameter int unsigned NUM_STAGES = SOS_NUM_STAGES,
   parameter int unsigned DW         = SOS_DW,
   parameter int unsigned TIMEOUT    = SOS_TIMEOUT
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DW-1:0]                 in_data,
   output logic                          bq_start,
   output logic [$clog2(NUM_STAGES)-1:0] bq_stage,
   output logic [DW-1:0]                 bq_x,
   input  logic                          bq_done,
   input  logic [DW-1:0]                 bq_y,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DW-1:0]                 out_data,
   output logic                          busy,
   input  logic                          err_clr,
   output logic                          err_timeout,
   output logic [SOS_CNT_W-1:0]          sample_cnt
);

   localparam int unsigned SW = $clog2(NUM_STAGES);
   localparam int unsigned WW = $clog2(TIMEOUT + 1);
   localparam logic [SW-1:0]        LAST_STAGE = SW'(NUM_STAGES - 1);
   localparam logic [SW-1:0]        STAGE_ONE  = SW'(1);
   localparam logic [WW-1:0]        WAIT_LAST  = WW'(TIMEOUT - 1);
   localparam logic [WW-1:0]        WAIT_ONE   = WW'(1);
   localparam logic [SOS_CNT_W-1:0] CNT_ONE    = SOS_CNT_W'(1);

   sos_state_e           state_q, state_d;
   logic [DW-1:0]        cur_q, cur_d;
   logic [SW-1:0]        stage_q, stage_d;
   logic [WW-1:0]        wait_q, wait_d;
   logic                 err_q, err_d;
   logic [SOS_CNT_W-1:0] cnt_q, cnt_d;
   logic                 out_valid_q, out_valid_d;
   logic [DW-1:0]        out_data_q, out_data_d;
   logic                 accept_s, xfer_s, timeout_s;

   assign accept_s  = (state_q == ST_IDLE) && enable && in_valid;
   assign xfer_s    = (state_q == ST_OUT) && out_valid_q && out_ready;
   assign timeout_s = (state_q == ST_WAIT) && !bq_done && (wait_q == WAIT_LAST);

   // State and datapath registers; reset drops any in-flight sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cur_q       <= '0;
         stage_q     <= '0;
         wait_q      <= '0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         stage_q     <= stage_d;
         wait_q      <= wait_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   // Next-state and datapath update; a result in WAIT wins over the timeout.
   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      stage_d = stage_q;
      wait_d  = wait_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               cur_d   = in_data;
               stage_d = '0;
               state_d = ST_ISSUE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            wait_d  = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (bq_done) begin
               cur_d = bq_y;
               if (stage_q == LAST_STAGE) begin
                  state_d = ST_OUT;
               end else begin
                  stage_d = stage_q + STAGE_ONE;
                  state_d = ST_ISSUE;
               end
            end else if (timeout_s) begin
               wait_d  = wait_q + WAIT_ONE;
               cur_d   = '0;
               state_d = ST_IDLE;
            end else begin
               wait_d = wait_q + WAIT_ONE;
            end
         end
         ST_OUT: begin
            if (xfer_s) begin
               cnt_d   = cnt_q + CNT_ONE;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_OUT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Sticky timeout flag and output register; a new timeout beats err_clr.
   always_comb begin
      if (timeout_s) begin
         err_d = 1'b1;
      end else if (err_clr) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end
      out_valid_d = (state_q == ST_OUT) && !xfer_s;
      out_data_d  = out_valid_d ? cur_q : '0;
   end

   // Outputs decoded from the state register (in_ready also needs enable).
   always_comb begin
      in_ready = 1'b0;
      bq_start = 1'b0;
      bq_x     = '0;
      busy     = 1'b1;
      case (state_q)
         ST_IDLE: begin
            in_ready = rst_n && enable;
            busy     = 1'b0;
         end
         ST_ISSUE: begin
            bq_start = 1'b1;
            bq_x     = cur_q;
         end
         ST_WAIT: begin
            busy = 1'b1;
         end
         ST_OUT: begin
            busy = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   assign bq_stage    = stage_q;
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign err_timeout = err_q;
   assign sample_cnt  = cnt_q;

endmodule

// File: tb/tb_sos_stage_sched.sv
// Directed bench for sos_stage_sched with a y=x+1 biquad model that answers
// on the first WAIT cycle. A negedge monitor keeps a scoreboard of expected
// outputs (pushed on acceptance, popped on each output transfer).
`timescale 1ns/1ps
module tb_sos_stage_sched;
   import sos_pkg::*;

   localparam int NS = 4;
   localparam int DW = 24;
   localparam int SW = 2;

   logic          clk = 1'b0;
   logic          rst_n, enable, in_valid, in_ready;
   logic [DW-1:0] in_data;
   logic          bq_start;
   logic [SW-1:0] bq_stage;
   logic [DW-1:0] bq_x;
   logic          bq_done = 1'b0;
   logic [DW-1:0] bq_y = '0;
   logic          out_valid, out_ready;
   logic [DW-1:0] out_data;
   logic          busy, err_clr, err_timeout;
   logic [10:0]   sample_cnt;

   int checks = 0;
   int failures = 0;
   int accepts = 0;
   int xfers = 0;
   int starts = 0;
   int valid_cycles = 0;
   logic [DW-1:0] sb_q[$];
   logic [SW-1:0] stage_log[$];
   logic          drop_en = 1'b0;
   logic [SW-1:0] drop_stage = '0;

   always #5 clk = ~clk;

   sos_stage_sched #(.NUM_STAGES(NS), .DW(DW), .TIMEOUT(64)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid),
      .in_ready(in_ready), .in_data(in_data), .bq_start(bq_start),
      .bq_stage(bq_stage), .bq_x(bq_x), .bq_done(bq_done), .bq_y(bq_y),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .err_clr(err_clr), .err_timeout(err_timeout),
      .sample_cnt(sample_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_stage_issue(input logic [SW-1:0] stg, input string tag);
      bit found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (bq_start && bq_stage == stg) found = 1'b1;
         else step(1);
      end
      chk(tag, 32'(found), 32'd1);
   endtask

   task automatic wait_xfers(input int target, input string tag);
      bit found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         step(1);
         if (xfers >= target) found = 1'b1;
      end
      chk(tag, 32'(found), 32'd1);
   endtask

   // Biquad model: result one cycle after bq_start, optionally silent on one stage.
   always @(posedge clk) begin
      bq_done <= bq_start && !(drop_en && bq_stage == drop_stage);
      bq_y    <= bq_x + 24'd1;
   end

   // Mid-cycle monitor: scoreboard push on acceptance, pop/compare on transfer.
   always @(negedge clk) begin
      if (rst_n) begin
         if (in_valid && in_ready) begin
            sb_q.push_back(in_data + 24'(NS));
            accepts++;
         end
         if (bq_start) begin
            stage_log.push_back(bq_stage);
            starts++;
         end
         if (out_valid) valid_cycles++;
         if (out_valid && out_ready) begin
            chk("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) chk("sb_out_data", 32'(out_data), 32'(sb_q.pop_front()));
            xfers++;
         end
      end
   end

   initial begin
      int n;
      bit found;
      int a0, x0, s0, vc0;

      rst_n = 1'b0; enable = 1'b1; in_valid = 1'b0; in_data = '0;
      out_ready = 1'b0; err_clr = 1'b0;
      #2;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_bq_start", 32'(bq_start), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sample_cnt", 32'(sample_cnt), 32'd0);
      chk("rst_err", 32'(err_timeout), 32'd0);
      step(3);
      #2 rst_n = 1'b1;
      step(2);
      chk("idle_in_ready", 32'(in_ready), 32'd1);

      // S1: 0x10 -> 0x14, latency 9, stage order 0..3
      out_ready = 1'b1; stage_log.delete();
      in_data = 24'h000010; in_valid = 1'b1;
      step(1);
      in_valid = 1'b0;
      chk("s1_busy", 32'(busy), 32'd1);
      chk("s1_in_ready_busy", 32'(in_ready), 32'd0);
      n = 0; found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         step(1); n++;
         if (out_valid) found = 1'b1;
      end
      chk("s1_out_seen", 32'(found), 32'd1);
      chk("s1_latency", 32'(n), 32'd9);
      chk("s1_out_data", 32'(out_data), 32'h14);
      step(2);
      chk("s1_stage_cnt", 32'(stage_log.size()), 32'd4);
      if (stage_log.size() == 4)
         for (int i = 0; i < 4; i++) chk($sformatf("s1_stage%0d", i), 32'(stage_log[i]), 32'(i));
      chk("s1_sample_cnt", 32'(sample_cnt), 32'd1);
      chk("s1_xfers", 32'(xfers), 32'd1);

      // S2: out_ready low 5 cycles in OUT, negative input passes through unsaturated
      out_ready = 1'b0;
      in_data = 24'hFFFFFD; in_valid = 1'b1;
      step(1);
      in_valid = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         step(1);
         if (out_valid) found = 1'b1;
      end
      chk("s2_out_seen", 32'(found), 32'd1);
      for (int i = 0; i < 5; i++) begin
         chk("s2_hold_valid", 32'(out_valid), 32'd1);
         chk("s2_hold_data", 32'(out_data), 32'h000001);
         chk("s2_hold_in_ready", 32'(in_ready), 32'd0);
         step(1);
      end
      out_ready = 1'b1;
      step(1);
      chk("s2_valid_drop", 32'(out_valid), 32'd0);
      chk("s2_sample_cnt", 32'(sample_cnt), 32'd2);
      chk("s2_xfers", 32'(xfers), 32'd2);

      // S3: stage 2 never answers; err_clr held high cannot beat the set
      drop_en = 1'b1; drop_stage = 2'd2; err_clr = 1'b1;
      vc0 = valid_cycles;
      in_data = 24'h000200; in_valid = 1'b1;
      step(1);
      in_valid = 1'b0;
      wait_stage_issue(2'd2, "s3_stage2_issue");
      n = 0; found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         step(1); n++;
         if (err_timeout) found = 1'b1;
      end
      chk("s3_err_seen", 32'(found), 32'd1);
      chk("s3_timeout_edges", 32'(n), 32'd65);
      chk("s3_idle", 32'(busy), 32'd0);
      chk("s3_in_ready", 32'(in_ready), 32'd1);
      chk("s3_no_valid", 32'(valid_cycles), 32'(vc0));
      chk("s3_sb_pending", 32'(sb_q.size()), 32'd1);
      if (sb_q.size() != 0) void'(sb_q.pop_front());
      err_clr = 1'b0; drop_en = 1'b0;
      step(3);
      chk("s3_err_sticky", 32'(err_timeout), 32'd1);
      err_clr = 1'b1;
      step(1);
      err_clr = 1'b0;
      chk("s3_err_cleared", 32'(err_timeout), 32'd0);
      chk("s3_sample_cnt", 32'(sample_cnt), 32'd2);

      // S4: enable low blocks acceptance; dropping it mid-sample does not abort
      enable = 1'b0; a0 = accepts;
      in_data = 24'h000300; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step(1);
         chk("s4_in_ready_off", 32'(in_ready), 32'd0);
         chk("s4_idle", 32'(busy), 32'd0);
      end
      chk("s4_no_accept", 32'(accepts), 32'(a0));
      enable = 1'b1; x0 = xfers;
      step(1);
      in_valid = 1'b0;
      wait_stage_issue(2'd1, "s4_stage1_issue");
      enable = 1'b0;
      wait_xfers(x0 + 1, "s4_completes");
      chk("s4_sample_cnt", 32'(sample_cnt), 32'd3);
      chk("s4_in_ready_after", 32'(in_ready), 32'd0);
      enable = 1'b1;
      step(1);

      // S5: reset during WAIT clears everything; next sample works
      in_data = 24'h000400; in_valid = 1'b1;
      step(1);
      in_valid = 1'b0;
      wait_stage_issue(2'd1, "s5_stage1_issue");
      step(1);
      rst_n = 1'b0;
      #1;
      chk("s5_in_ready", 32'(in_ready), 32'd0);
      chk("s5_bq_start", 32'(bq_start), 32'd0);
      chk("s5_bq_stage", 32'(bq_stage), 32'd0);
      chk("s5_bq_x", 32'(bq_x), 32'd0);
      chk("s5_out_valid", 32'(out_valid), 32'd0);
      chk("s5_out_data", 32'(out_data), 32'd0);
      chk("s5_busy", 32'(busy), 32'd0);
      chk("s5_err", 32'(err_timeout), 32'd0);
      chk("s5_sample_cnt", 32'(sample_cnt), 32'd0);
      sb_q.delete(); vc0 = valid_cycles;
      step(2);
      #2 rst_n = 1'b1;
      step(2);
      chk("s5_no_output", 32'(valid_cycles), 32'(vc0));
      x0 = xfers;
      in_data = 24'h000500; in_valid = 1'b1;
      step(1);
      in_valid = 1'b0;
      wait_xfers(x0 + 1, "s5_after_reset");
      chk("s5_cnt_after", 32'(sample_cnt), 32'd1);

      // S6: 2048 back-to-back samples from a fresh reset
      rst_n = 1'b0;
      step(2);
      #2 rst_n = 1'b1;
      step(2);
      sb_q.delete();
      a0 = accepts; x0 = xfers; s0 = starts;
      out_ready = 1'b1; in_data = 24'($urandom); in_valid = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 30000 && !found; i++) begin
         step(1);
         in_data = 24'($urandom);
         if (accepts - a0 >= 2048) in_valid = 1'b0;
         if (xfers - x0 >= 2048) found = 1'b1;
      end
      in_valid = 1'b0;
      chk("s6_done", 32'(found), 32'd1);
      chk("s6_accepts", 32'(accepts - a0), 32'd2048);
      chk("s6_sample_cnt_wrap", 32'(sample_cnt), 32'd0);
      chk("s6_bq_starts", 32'(starts - s0), 32'd8192);
      chk("s6_sb_empty", 32'(sb_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sos_stage_sched.md
SOS_STAGE_SCHED -- requirements
Module: sos_stage_sched

Interface
REQ-001 Parameter NUM_STAGES, default 4, SHALL set the number of cascaded biquad stages time-shared on one biquad unit.
REQ-002 Parameter DW, default 24, SHALL set the signed sample width.
REQ-003 Parameter TIMEOUT, default 64, SHALL set the maximum WAIT cycles per stage; SW = clog2(NUM_STAGES).
REQ-004 The ports SHALL be exactly:
- clk  in  1  sole clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  permits new sample acceptance.
- in_valid  in  1  input sample offered.
- in_ready  out  1  scheduler can accept a sample.
- in_data  in  DW  signed input sample.
- bq_start  out  1  one-cycle strobe that launches the biquad unit.
- bq_stage  out  SW  stage index for the biquad unit (coefficients and state select).
- bq_x  out  DW  signed stage input.
- bq_done  in  1  biquad result valid.
- bq_y  in  DW  signed stage result.
- out_valid  out  1  filtered sample available.
- out_ready  in  1  downstream accepts the sample.
- out_data  out  DW  signed filtered sample.
- busy  out  1  state is not IDLE.
- err_clr  in  1  clears err_timeout.
- err_timeout  out  1  sticky stage-timeout flag.
- sample_cnt  out  11  count of completed output transfers.

Function
REQ-005 The FSM SHALL have states IDLE, ISSUE, WAIT and OUT; all outputs SHALL be registered or decoded from the state register only.
REQ-006 In IDLE, in_ready SHALL equal enable; in_valid && in_ready at an edge SHALL latch in_data into cur, clear the stage index to 0 and go to ISSUE.
REQ-007 In ISSUE, the block SHALL hold bq_start=1 for exactly one cycle, drive bq_x=cur and bq_stage=stage, clear the wait counter and go to WAIT.
REQ-008 In WAIT, bq_done=1 SHALL load bq_y into cur.
- If stage==NUM_STAGES-1, the FSM SHALL go to OUT.
- Otherwise stage SHALL increment and the FSM SHALL go to ISSUE.
REQ-009 In WAIT without bq_done, the wait counter SHALL increment; when it reaches TIMEOUT, the block SHALL set err_timeout, discard the sample and go to IDLE.
REQ-010 If bq_done and the timeout condition occur in the same cycle, bq_done SHALL win and err_timeout SHALL not be set.
REQ-011 bq_done outside WAIT SHALL be ignored.
REQ-012 In OUT, out_valid=1 and out_data=cur SHALL be held stable until out_ready=1. On that transfer edge, sample_cnt SHALL increment (wrapping 2047->0) and the FSM SHALL go to IDLE.
REQ-013 in_ready SHALL be 0 in every state other than IDLE; exactly one sample SHALL be in flight at a time.
REQ-014 Latency: with bq_done asserted in the first WAIT cycle, out_valid SHALL rise 2*NUM_STAGES+1 edges after the accepting edge.
REQ-015 Deasserting enable mid-sample SHALL NOT abort that sample; it SHALL only block the next acceptance.
REQ-016 err_clr SHALL clear err_timeout; if err_clr and a new timeout occur in the same cycle, the set SHALL win.
REQ-017 Arithmetic SHALL be pass-through only: no saturation or rescaling of bq_y.

Reset
REQ-018 On rst_n low, the block SHALL asynchronously enter IDLE and force to 0: in_ready, bq_start, bq_stage, bq_x, out_valid, out_data, busy, err_timeout, sample_cnt, cur, stage and the wait counter.
REQ-019 A reset mid-operation SHALL drop the in-flight sample with no output.

Structure
REQ-020 The FSM state encoding and the defaults for NUM_STAGES, DW and TIMEOUT SHALL live in the shared package sos_pkg.
REQ-021 The block SHALL be a single module with no sub-modules; the biquad unit SHALL be external.

Verification
REQ-022 The bench SHALL cover these directed scenarios (NUM_STAGES=4; bench biquad model y=x+1 with done on the first WAIT cycle):
- in_data 0x000010 -> out_data 0x000014, out_valid at edge 9 after acceptance, bq_stage sequence 0,1,2,3.
- out_ready held low 5 cycles in OUT -> out_valid and out_data stable, in_ready=0, exactly one transfer, sample_cnt +1.
- bq_done never returned on stage 2 -> err_timeout=1 after 64 WAIT cycles, back in IDLE, no out_valid; err_clr pulse -> err_timeout=0.
- enable=0 with in_valid=1 -> no acceptance; enable dropped during stage 1 -> that sample still completes.
- rst_n asserted during WAIT -> all outputs 0 immediately; next sample after reset processes normally.
- 2048 back-to-back samples -> sample_cnt wraps to 0 and bq_start count is 8192.
